debounce_bank: RTL and testbench
================================

DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  CHANNELS, 4, number of independent input channels.
  DELAY, 270000, stable-sample count before an output change (0.01 s at 27 MHz).
  CNT_W, 19, per-channel stability counter width; SHALL satisfy 2^CNT_W > DELAY.
  REPEAT_FIRST, 13500000, cycles from a rise pulse to the first repeat pulse.
  REPEAT_RATE, 2700000, cycles between later repeat pulses.
  RPT_W, 24, repeat counter width; SHALL satisfy 2^RPT_W > max(REPEAT_FIRST, REPEAT_RATE).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clock, input, 1, single clock for all logic.
  reset, input, 1, asynchronous active-low reset.
  noisy, input, CHANNELS, raw asynchronous switch inputs.
  clean, output, CHANNELS, debounced levels.
  rise, output, CHANNELS, one-cycle pulse when clean goes 0->1.
  fall, output, CHANNELS, one-cycle pulse when clean goes 1->0.
  repeat, output, CHANNELS, one-cycle auto-repeat pulse while clean is held high.
  any_event, output, 1, OR of all rise and fall bits.
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-low (reset=0 resets).

Function
REQ-004 Each noisy bit SHALL pass through a two-flop synchroniser (s1, s2) before any other use.
REQ-005 Each channel SHALL hold a candidate bit cand and a counter cnt[CNT_W-1:0].
REQ-006 Per edge, when s2 != cand: cand <= s2 and cnt <= 0.
REQ-007 Per edge, when s2 == cand and cnt < DELAY: cnt <= cnt+1. cnt SHALL saturate at DELAY and never wrap.
REQ-008 Per edge, when s2 == cand, cnt == DELAY and clean != cand: clean <= cand; in the same edge rise or fall SHALL be registered high per direction.
REQ-009 Latency: noisy first sampled at a new value on edge k and held stable SHALL update clean at edge k+DELAY+3.
REQ-010 Any s2 excursion shorter than DELAY+1 cycles SHALL leave clean unchanged and SHALL produce no pulse.
REQ-011 rise, fall and repeat SHALL each be high for exactly one cycle per event; rise and fall on one channel SHALL never be high in the same cycle.
REQ-012 Channels SHALL be fully independent; simultaneous events on several channels SHALL all pulse in the same cycle.
REQ-013 any_event SHALL be registered and coincident with the rise/fall pulses it reflects.
REQ-014 DELAY=0 SHALL be legal: clean follows s2 one cycle after cand updates.

Reset
REQ-015 While reset=0: s1, s2, cand, clean, rise, fall, repeat and any_event SHALL be 0; cnt and repeat counters SHALL be 0.
REQ-016 Reset asserted mid-count SHALL abandon the count; after release, an input held at 1 SHALL be treated as a new 0->1 change (full REQ-009 latency, rise pulse).

Configuration
REQ-017 With macro DEBOUNCE_REPEAT_EN defined, each channel SHALL have an RPT_W repeat counter.
  The counter SHALL clear on the rise pulse.
  repeat SHALL pulse REPEAT_FIRST cycles after rise, then every REPEAT_RATE cycles while clean stays 1.
  A fall or reset SHALL clear the counter and stop pulses immediately.
REQ-018 Without DEBOUNCE_REPEAT_EN, repeat SHALL be constant 0 and no repeat counters SHALL be synthesised; the port SHALL remain.

Verification (CHANNELS=4, DELAY=4, REPEAT_FIRST=8, REPEAT_RATE=3)
REQ-019 Hold reset=0 for 3 cycles with noisy=4'hF, then release -> all outputs 0 during reset; clean=4'hF and rise=4'hF for one cycle at 7 edges after release.
REQ-020 Step noisy[0] 0->1, sampled at edge 10 -> clean[0]=1 and rise[0]=1 at edge 17; rise[0]=0 at edge 18; any_event high for that one cycle only.
REQ-021 Pulse noisy[1] high for 3 cycles, or toggle it every 2 cycles 5 times and then hold it -> no change for the glitch; for the toggling, clean[1] changes exactly 7 edges after the final transition is sampled.
REQ-022 Make noisy[2] rise and noisy[3] fall on the same edge -> rise[2] and fall[3] both high in the same single cycle; any_event=1 for one cycle.
REQ-023 Assert reset with cnt[0]=2 mid-rise, then release with noisy[0]=1 -> clean[0] stays 0 until 7 edges after release.
REQ-024 With DEBOUNCE_REPEAT_EN, hold clean[0]=1 -> repeat[0] pulses 8, 11 and 14 cycles after rise[0]; releasing noisy[0] stops the pulses at the fall. Without the macro -> repeat stays 0.

Source files
------------

// File: rtl/debounce_bank.sv
// Bank of independent switch debouncers with rise/fall pulses and optional auto-repeat.
// Define DEBOUNCE_REPEAT_EN to build the per-channel auto-repeat counters.
module debounce_bank #(
   parameter int CHANNELS     = 4,
   parameter int DELAY        = 270000,
   parameter int CNT_W        = 19,
   parameter int REPEAT_FIRST = 13500000,
   parameter int REPEAT_RATE  = 2700000,
   parameter int RPT_W        = 24
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [CHANNELS-1:0] noisy,
   output logic [CHANNELS-1:0] clean,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic [CHANNELS-1:0] repeat_pulse,
   output logic                any_event
);

   if ((64'd1 << CNT_W) <= 64'(DELAY)) begin : g_cnt_w_check
      $error("CNT_W too narrow for DELAY");
   end
   if (((64'd1 << RPT_W) <= 64'(REPEAT_FIRST)) || ((64'd1 << RPT_W) <= 64'(REPEAT_RATE))) begin : g_rpt_w_check
      $error("RPT_W too narrow for repeat intervals");
   end

   logic [CHANNELS-1:0] s1, s2, cand;
   logic [CHANNELS-1:0] cand_d, clean_d, rise_d, fall_d;
   logic [CNT_W-1:0]    cnt   [CHANNELS];
   logic [CNT_W-1:0]    cnt_d [CHANNELS];

   // A change of s2 restarts the count; clean follows cand only after DELAY stable samples.
   always_comb begin
      cand_d  = cand;
      clean_d = clean;
      rise_d  = '0;
      fall_d  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_d[i] = cnt[i];
         if (s2[i] != cand[i]) begin
            cand_d[i] = s2[i];
            cnt_d[i]  = '0;
         end else if (cnt[i] < CNT_W'(DELAY)) begin
            cnt_d[i] = cnt[i] + 1'b1;
         end else if (clean[i] != cand[i]) begin
            clean_d[i] = cand[i];
            rise_d[i]  = cand[i];
            fall_d[i]  = ~cand[i];
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1        <= '0;
         s2        <= '0;
         cand      <= '0;
         clean     <= '0;
         rise      <= '0;
         fall      <= '0;
         any_event <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
      end else begin
         s1        <= noisy;
         s2        <= s1;
         cand      <= cand_d;
         clean     <= clean_d;
         rise      <= rise_d;
         fall      <= fall_d;
         any_event <= |(rise_d | fall_d);
         for (int i = 0; i < CHANNELS; i++) cnt[i] <= cnt_d[i];
      end
   end

`ifdef DEBOUNCE_REPEAT_EN
   logic [RPT_W-1:0]    rpt_cnt [CHANNELS];
   logic [CHANNELS-1:0] rpt_first;

   // rpt_first selects the long initial interval; later pulses use the short rate.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         repeat_pulse <= '0;
         rpt_first    <= '0;
         for (int i = 0; i < CHANNELS; i++) rpt_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            repeat_pulse[i] <= 1'b0;
            if (rise_d[i]) begin
               rpt_cnt[i]   <= '0;
               rpt_first[i] <= 1'b1;
            end else if (!clean_d[i]) begin
               rpt_cnt[i]   <= '0;
               rpt_first[i] <= 1'b0;
            end else if (rpt_cnt[i] == (rpt_first[i] ? RPT_W'(REPEAT_FIRST - 1)
                                                     : RPT_W'(REPEAT_RATE - 1))) begin
               repeat_pulse[i] <= 1'b1;
               rpt_cnt[i]      <= '0;
               rpt_first[i]    <= 1'b0;
            end else begin
               rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
            end
         end
      end
   end
`else
   assign repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: reset, latency, glitch rejection, simultaneous events, repeat.
module tb_debounce_bank;
   localparam int CH = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic [CH-1:0] noisy;
   logic [CH-1:0] clean, rise, fall, repeat_pulse;
   logic          any_event;

   int            errors = 0;
   int            checks = 0;
   logic [CH-1:0] exp_q[$];
   logic [CH-1:0] ev_acc      = '0;
   logic [CH-1:0] overlap_acc = '0;

   always #5 clock = ~clock;

   debounce_bank #(
      .CHANNELS(CH), .DELAY(4), .CNT_W(4),
      .REPEAT_FIRST(8), .REPEAT_RATE(3), .RPT_W(4)
   ) dut (
      .clock(clock), .reset(reset), .noisy(noisy), .clean(clean), .rise(rise),
      .fall(fall), .repeat_pulse(repeat_pulse), .any_event(any_event)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one active edge and sample 1 time unit later.
   task automatic step();
      @(posedge clock);
      #1;
      ev_acc      = ev_acc | rise | fall;
      overlap_acc = overlap_acc | (rise & fall);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   function automatic logic [CH-1:0] exp_repeat(input int off);
`ifdef DEBOUNCE_REPEAT_EN
      case (off)
         8, 11, 14, 17, 20: return 4'b0111;
         23, 26:            return 4'b0110;
         default:           return 4'b0000;
      endcase
`else
      return (off < 0) ? 4'b1111 : 4'b0000;
`endif
   endfunction

   initial begin
      reset = 1'b0;
      noisy = 4'hF;
      steps(3);
      check("reset_clean", clean, 0);
      check("reset_rise_fall", {rise, fall}, 0);
      check("reset_repeat", repeat_pulse, 0);
      check("reset_any", any_event, 0);

      reset = 1'b1;
      steps(7);
      check("rel_clean_e7", clean, 4'h0);
      step();
      check("rel_clean_e8", clean, 4'hF);
      check("rel_rise_e8", rise, 4'hF);
      check("rel_any_e8", any_event, 1);
      step();
      check("rel_rise_e9", rise, 4'h0);
      check("rel_any_e9", any_event, 0);

      noisy = 4'h0;
      steps(12);
      check("settle_low", clean, 4'h0);

      noisy = 4'b0001;
      steps(7);
      check("step0_clean_early", clean, 4'b0000);
      check("step0_any_early", any_event, 0);
      step();
      check("step0_clean", clean, 4'b0001);
      check("step0_rise", rise, 4'b0001);
      check("step0_any", any_event, 1);
      step();
      check("step0_rise_off", rise, 4'b0000);
      check("step0_any_off", any_event, 0);

      ev_acc = '0;
      noisy[1] = 1'b1;
      steps(3);
      noisy[1] = 1'b0;
      steps(12);
      check("glitch_events", ev_acc, 0);
      check("glitch_clean", clean, 4'b0001);

      ev_acc = '0;
      for (int t = 0; t < 5; t++) begin
         noisy[1] = ~noisy[1];
         if (t < 4) steps(2);
      end
      steps(7);
      check("toggle_events", ev_acc, 0);
      check("toggle_clean_early", clean, 4'b0001);
      step();
      check("toggle_clean", clean, 4'b0011);
      check("toggle_rise", rise, 4'b0010);
      step();
      check("toggle_rise_off", rise, 4'b0000);

      noisy[3] = 1'b1;
      steps(12);
      check("ch3_high", clean, 4'b1011);

      ev_acc = '0;
      noisy[2] = 1'b1;
      noisy[3] = 1'b0;
      steps(7);
      check("simul_early", ev_acc, 0);
      step();
      check("simul_rise", rise, 4'b0100);
      check("simul_fall", fall, 4'b1000);
      check("simul_any", any_event, 1);
      check("simul_clean", clean, 4'b0111);
      step();
      check("simul_off", {rise, fall}, 0);
      check("simul_any_off", any_event, 0);

      noisy[0] = 1'b0;
      steps(12);
      check("ch0_low", clean, 4'b0110);
      noisy[0] = 1'b1;
      steps(5);
      reset = 1'b0;
      #1;
      check("midrst_clean", clean, 0);
      check("midrst_pulses", {rise, fall, repeat_pulse}, 0);
      check("midrst_any", any_event, 0);
      steps(2);
      reset = 1'b1;
      steps(7);
      check("midrst_clean_e7", clean, 4'b0000);
      step();
      check("midrst_clean_e8", clean, 4'b0111);
      check("midrst_rise_e8", rise, 4'b0111);

      for (int off = 1; off <= 27; off++) exp_q.push_back(exp_repeat(off));
      for (int off = 1; off <= 27; off++) begin
         step();
         check($sformatf("repeat_off%0d", off), repeat_pulse, exp_q.pop_front());
         if (off == 23) check("repeat_fall0", fall, 4'b0001);
         if (off == 15) noisy[0] = 1'b0;
      end

      check("rise_fall_excl", overlap_acc, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
